// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: shares the LOAD/D port of a register bank between three
// write requesters (0 = ALU writeback, 1 = memory load, 2 = I/O) using a
// 3-way round-robin with registered outputs.
//
// Ports:
//   clk          - system clock, rising edge
//   clr          - synchronous active-high reset
//   req[2:0]     - write request, bit i from requester i
//   addr0..2     - target register per requester
//   data0..2     - write data per requester
//   gnt[2:0]     - one-hot grant pulse (registered)
//   load         - one-hot per-register LOAD to the bank (registered)
//   wr_data      - D input to the bank (registered, holds when idle)
//   busy         - any eligible request pending (combinational)
//   conflict_cnt - saturating count of edges with two or more eligible requests
//
// Optional build macro:
//   R0_PROTECT_EN - register 0 is hardwired zero; writes to it are granted
//                   but never raise load[0].
module reg_write_arbiter #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [2:0]          req,
    input  logic [ADDR_W-1:0]   addr0,
    input  logic [ADDR_W-1:0]   addr1,
    input  logic [ADDR_W-1:0]   addr2,
    input  logic [DATA_W-1:0]   data0,
    input  logic [DATA_W-1:0]   data1,
    input  logic [DATA_W-1:0]   data2,
    output logic [2:0]          gnt,
    output logic [NUM_REGS-1:0] load,
    output logic [DATA_W-1:0]   wr_data,
    output logic                busy,
    output logic [CNT_W-1:0]    conflict_cnt
);

    logic [1:0]          ptr_q, ptr_d;
    logic [2:0]          gnt_q, gnt_d;
    logic [NUM_REGS-1:0] load_q, load_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [2:0]          elig;
    logic [1:0]          ord [3];
    logic                win_valid;
    logic [1:0]          win;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic                multi;

    // The requester granted last cycle is masked so it can advance its
    // req/addr/data before being considered again.
    assign elig = req & ~gnt_q;
    assign busy = |elig;
    assign multi = (elig[0] & elig[1]) | (elig[0] & elig[2]) | (elig[1] & elig[2]);

    always_comb begin
        // Search order starting at the priority pointer.
        ord[0] = 2'd0;
        ord[1] = 2'd1;
        ord[2] = 2'd2;
        case (ptr_q)
            2'd1: begin
                ord[0] = 2'd1;
                ord[1] = 2'd2;
                ord[2] = 2'd0;
            end
            2'd2: begin
                ord[0] = 2'd2;
                ord[1] = 2'd0;
                ord[2] = 2'd1;
            end
            default: ;
        endcase

        win_valid = 1'b0;
        win       = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (!win_valid && elig[ord[k]]) begin
                win_valid = 1'b1;
                win       = ord[k];
            end
        end
    end

    always_comb begin
        win_addr = addr0;
        win_data = data0;
        case (win)
            2'd1: begin
                win_addr = addr1;
                win_data = data1;
            end
            2'd2: begin
                win_addr = addr2;
                win_data = data2;
            end
            default: ;
        endcase
    end

    always_comb begin
        gnt_d     = 3'b000;
        load_d    = '0;
        wr_data_d = wr_data_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;

        if (win_valid) begin
            gnt_d[win] = 1'b1;
            wr_data_d  = win_data;
            ptr_d      = (win == 2'd2) ? 2'd0 : win + 2'd1;
            // Addresses at or beyond NUM_REGS match no bit: write dropped.
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (win_addr == ADDR_W'(r)) begin
                    load_d[r] = 1'b1;
                end
            end
`ifdef R0_PROTECT_EN
            load_d[0] = 1'b0;
`else
`endif
        end

        if (multi && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            ptr_q     <= 2'd0;
            gnt_q     <= 3'b000;
            load_q    <= '0;
            wr_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            load_q    <= load_d;
            wr_data_q <= wr_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt          = gnt_q;
    assign load         = load_q;
    assign wr_data      = wr_data_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Testbench for reg_write_arbiter: table-driven vectors followed by
// hand-written masking, saturation and reset sequences. A second instance with
// NUM_REGS=6 shares the inputs to exercise out-of-range addresses.
module tb_reg_write_arbiter;

    logic        clk;
    logic        clr;
    logic [2:0]  req;
    logic [2:0]  addr0, addr1, addr2;
    logic [15:0] data0, data1, data2;
    logic [2:0]  gnt, gnt6;
    logic [7:0]  load;
    logic [5:0]  load6;
    logic [15:0] wr_data, wr_data6;
    logic        busy, busy6;
    logic [7:0]  conflict_cnt, conflict_cnt6;

    int n_pass  = 0;
    int n_total = 0;

    reg_write_arbiter dut (
        .clk          (clk),
        .clr          (clr),
        .req          (req),
        .addr0        (addr0),
        .addr1        (addr1),
        .addr2        (addr2),
        .data0        (data0),
        .data1        (data1),
        .data2        (data2),
        .gnt          (gnt),
        .load         (load),
        .wr_data      (wr_data),
        .busy         (busy),
        .conflict_cnt (conflict_cnt)
    );

    reg_write_arbiter #(.NUM_REGS(6)) dut6 (
        .clk          (clk),
        .clr          (clr),
        .req          (req),
        .addr0        (addr0),
        .addr1        (addr1),
        .addr2        (addr2),
        .data0        (data0),
        .data1        (data1),
        .data2        (data2),
        .gnt          (gnt6),
        .load         (load6),
        .wr_data      (wr_data6),
        .busy         (busy6),
        .conflict_cnt (conflict_cnt6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic [2:0]  req;
        logic [2:0]  a0, a1, a2;
        logic [15:0] d0, d1, d2;
        logic [2:0]  gnt;
        logic [7:0]  load;
        logic [5:0]  load6;
        logic [15:0] wr;
        logic [7:0]  cnt;
        logic        busy;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    function automatic vec_t mk(logic c, logic [2:0] r, logic [2:0] a0, logic [2:0] a1,
                                logic [2:0] a2, logic [15:0] d0, logic [15:0] d1,
                                logic [15:0] d2, logic [2:0] g, logic [7:0] l,
                                logic [5:0] l6, logic [15:0] w, logic [7:0] cn, logic b);
        vec_t v;
        v.clr = c;  v.req = r;  v.a0 = a0; v.a1 = a1; v.a2 = a2;
        v.d0 = d0;  v.d1 = d1;  v.d2 = d2;
        v.gnt = g;  v.load = l; v.load6 = l6; v.wr = w; v.cnt = cn; v.busy = b;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] r0_load;

    initial begin
`ifdef R0_PROTECT_EN
        r0_load = 8'h00;
`else
        r0_load = 8'h01;
`endif
        //          clr req   a0 a1 a2  d0       d1       d2       gnt   load   load6  wr       cnt busy
        vecs[0]  = mk(1, 3'b111, 1, 2, 3, 16'h1111, 16'h2222, 16'h3333, 3'b000, 8'h00, 6'h00, 16'h0000, 0, 1);
        vecs[1]  = mk(1, 3'b111, 1, 2, 3, 16'h1111, 16'h2222, 16'h3333, 3'b000, 8'h00, 6'h00, 16'h0000, 0, 1);
        vecs[2]  = mk(0, 3'b111, 1, 2, 3, 16'h1111, 16'h2222, 16'h3333, 3'b001, 8'h02, 6'h02, 16'h1111, 1, 1);
        vecs[3]  = mk(0, 3'b111, 1, 2, 3, 16'h1111, 16'h2222, 16'h3333, 3'b010, 8'h04, 6'h04, 16'h2222, 2, 1);
        vecs[4]  = mk(0, 3'b111, 1, 2, 3, 16'h1111, 16'h2222, 16'h3333, 3'b100, 8'h08, 6'h08, 16'h3333, 3, 1);
        vecs[5]  = mk(0, 3'b111, 1, 2, 3, 16'h1111, 16'h2222, 16'h3333, 3'b001, 8'h02, 6'h02, 16'h1111, 4, 1);
        vecs[6]  = mk(0, 3'b111, 1, 2, 3, 16'h1111, 16'h2222, 16'h3333, 3'b010, 8'h04, 6'h04, 16'h2222, 5, 1);
        vecs[7]  = mk(0, 3'b111, 1, 2, 3, 16'h1111, 16'h2222, 16'h3333, 3'b100, 8'h08, 6'h08, 16'h3333, 6, 1);
        vecs[8]  = mk(0, 3'b000, 1, 2, 3, 16'h1111, 16'h2222, 16'h3333, 3'b000, 8'h00, 6'h00, 16'h3333, 6, 0);
        vecs[9]  = mk(0, 3'b001, 1, 2, 3, 16'h1111, 16'h2222, 16'h3333, 3'b001, 8'h02, 6'h02, 16'h1111, 6, 0);
        vecs[10] = mk(0, 3'b001, 1, 2, 3, 16'h1111, 16'h2222, 16'h3333, 3'b000, 8'h00, 6'h00, 16'h1111, 6, 1);
        vecs[11] = mk(0, 3'b001, 1, 2, 3, 16'h1111, 16'h2222, 16'h3333, 3'b001, 8'h02, 6'h02, 16'h1111, 6, 0);
        vecs[12] = mk(0, 3'b001, 1, 2, 3, 16'h1111, 16'h2222, 16'h3333, 3'b000, 8'h00, 6'h00, 16'h1111, 6, 1);
        vecs[13] = mk(0, 3'b010, 1, 5, 3, 16'h1111, 16'hA5A5, 16'h3333, 3'b010, 8'h20, 6'h20, 16'hA5A5, 6, 0);
        vecs[14] = mk(0, 3'b000, 1, 5, 3, 16'h1111, 16'hA5A5, 16'h3333, 3'b000, 8'h00, 6'h00, 16'hA5A5, 6, 0);
        vecs[15] = mk(0, 3'b100, 1, 5, 7, 16'h1111, 16'hA5A5, 16'hBEEF, 3'b100, 8'h80, 6'h00, 16'hBEEF, 6, 0);
        vecs[16] = mk(0, 3'b000, 1, 5, 7, 16'h1111, 16'hA5A5, 16'hBEEF, 3'b000, 8'h00, 6'h00, 16'hBEEF, 6, 0);
        vecs[17] = mk(1, 3'b011, 1, 5, 7, 16'h1111, 16'hA5A5, 16'hBEEF, 3'b000, 8'h00, 6'h00, 16'h0000, 0, 1);
        vecs[18] = mk(0, 3'b011, 1, 5, 7, 16'h1111, 16'hA5A5, 16'hBEEF, 3'b001, 8'h02, 6'h02, 16'h1111, 1, 1);
        vecs[19] = mk(0, 3'b010, 1, 5, 7, 16'h1111, 16'hA5A5, 16'hBEEF, 3'b010, 8'h20, 6'h20, 16'hA5A5, 1, 0);
        vecs[20] = mk(0, 3'b001, 0, 5, 7, 16'hFFFF, 16'hA5A5, 16'hBEEF, 3'b001, r0_load,
                      r0_load[5:0], 16'hFFFF, 1, 0);
        vecs[21] = mk(0, 3'b000, 0, 5, 7, 16'hFFFF, 16'hA5A5, 16'hBEEF, 3'b000, 8'h00, 6'h00, 16'hFFFF, 1, 0);

        clr = 1'b1; req = 3'b000;
        addr0 = '0; addr1 = '0; addr2 = '0;
        data0 = '0; data1 = '0; data2 = '0;
        #1;

        for (int i = 0; i < NV; i++) begin
            clr = vecs[i].clr; req = vecs[i].req;
            addr0 = vecs[i].a0; addr1 = vecs[i].a1; addr2 = vecs[i].a2;
            data0 = vecs[i].d0; data1 = vecs[i].d1; data2 = vecs[i].d2;
            tick();
            check($sformatf("v%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            check($sformatf("v%0d load", i), 32'(load), 32'(vecs[i].load));
            check($sformatf("v%0d wr_data", i), 32'(wr_data), 32'(vecs[i].wr));
            check($sformatf("v%0d conflict_cnt", i), 32'(conflict_cnt), 32'(vecs[i].cnt));
            check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("v%0d load6", i), 32'(load6), 32'(vecs[i].load6));
            check($sformatf("v%0d gnt6", i), 32'(gnt6), 32'(vecs[i].gnt));
        end

        // Masking: a lone requester held high is granted every other cycle.
        clr = 1'b1; req = 3'b000;
        tick();
        clr = 1'b0; req = 3'b001; addr0 = 3'd2; data0 = 16'h0C0C;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("mask%0d gnt", i), 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h0);
            check($sformatf("mask%0d load", i), 32'(load), (i % 2 == 0) ? 32'h4 : 32'h0);
        end

        // Saturation: continuous three-way contention counts every edge.
        clr = 1'b1; req = 3'b000;
        tick();
        clr = 1'b0; req = 3'b111;
        for (int e = 1; e <= 300; e++) begin
            tick();
            check($sformatf("sat%0d gnt onehot", e), 32'($onehot(gnt)), 32'h1);
            check($sformatf("sat%0d load onehot", e), 32'($onehot(load)), 32'h1);
            if (e == 100) check("sat cnt@100", 32'(conflict_cnt), 32'd100);
            if (e == 254) check("sat cnt@254", 32'(conflict_cnt), 32'd254);
            if (e == 255) check("sat cnt@255", 32'(conflict_cnt), 32'd255);
            if (e == 300) check("sat cnt@300", 32'(conflict_cnt), 32'd255);
        end

        // Only clr clears the counter.
        clr = 1'b1;
        tick();
        check("clr cnt", 32'(conflict_cnt), 32'd0);
        check("clr gnt", 32'(gnt), 32'd0);
        check("clr load", 32'(load), 32'd0);
        check("clr wr_data", 32'(wr_data), 32'd0);
        clr = 1'b0;
        tick();
        check("post-clr first gnt", 32'(gnt), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
